// File: rtl/lane_sweep_pkg.sv
// Shared types and default sizing for the lane sweep block.
// Holds the mode and FSM state encodings used by lane_sweep and lane_if.
package lane_sweep_pkg;

    localparam int N_LANES_DEF = 8;
    localparam int WIDTH_DEF   = 1;

    typedef enum logic {
        MODE_BROADCAST = 1'b0,
        MODE_SWEEP     = 1'b1
    } mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/lane_if.sv
// Bundle of N_LANES lanes, each WIDTH bits; drv is the writer view, mon the reader view.
// Pure wiring, no state.
interface lane_if
    import lane_sweep_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int WIDTH   = WIDTH_DEF
);

    logic [WIDTH-1:0] lanes [N_LANES-1:0];

    modport drv (output lanes);
    modport mon (input lanes);

endinterface

// File: rtl/lane_sweep.sv
// Fills a registered lane array in one edge (BROADCAST) or one lane per edge (SWEEP); LANE_SWEEP_INCR_EN adds lane index to swept values.
// Latency: broadcast 1 edge; sweep writes lane k at edge t+1+k, o_done in the cycle after edge t+N_LANES.
// Backpressure: none; i_start is ignored while sweeping, i_abort cancels a sweep or suppresses a start.
module lane_sweep
    import lane_sweep_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    lane_if.drv              p,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done
);

    localparam int            IW       = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_LANES - 1);

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_val;
    logic             r_done;
    logic [WIDTH-1:0] r_lanes     [N_LANES-1:0];
    logic [WIDTH-1:0] w_sweep_dat [N_LANES-1:0];
    logic             w_go;

    assign w_go = i_start && !i_abort;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
`ifdef LANE_SWEEP_INCR_EN
        assign w_sweep_dat[g] = r_val + WIDTH'(g);
`else
        assign w_sweep_dat[g] = r_val;
`endif
        assign p.lanes[g] = r_lanes[g];
    end

    // Lane 0 is always written straight from i_value: its increment offset is zero.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_val   <= '0;
            r_done  <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                r_lanes[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        if (mode_t'(i_mode) == MODE_BROADCAST) begin
                            for (int k = 0; k < N_LANES; k++) begin
                                r_lanes[k] <= i_value;
                            end
                            r_done <= 1'b1;
                        end else begin
                            r_lanes[0] <= i_value;
                            r_val      <= i_value;
                            if (N_LANES == 1) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_SWEEP;
                                r_idx   <= IW'(1);
                            end
                        end
                    end
                end
                ST_SWEEP: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else begin
                        // Decoded compare keeps the write inside the array for any N_LANES.
                        for (int k = 0; k < N_LANES; k++) begin
                            if (r_idx == IW'(k)) begin
                                r_lanes[k] <= w_sweep_dat[k];
                            end
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_IDLE;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_busy = (r_state == ST_SWEEP);
    assign o_done = r_done;

endmodule

// File: tb/tb_lane_sweep.sv
// Directed bench for lane_sweep across four sizings: 8x1, 4x8, 1x4 and 4x4.
// Expected swept values on the 4x4 instance follow LANE_SWEEP_INCR_EN.
module tb_lane_sweep;
    import lane_sweep_pkg::*;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    logic       a_start, a_mode, a_abort, a_busy, a_done;
    logic [0:0] a_value;
    logic       b_start, b_mode, b_abort, b_busy, b_done;
    logic [7:0] b_value;
    logic       c_start, c_mode, c_abort, c_busy, c_done;
    logic [3:0] c_value;
    logic       d_start, d_mode, d_abort, d_busy, d_done;
    logic [3:0] d_value;

    lane_if #(.N_LANES(8), .WIDTH(1)) if_a ();
    lane_if #(.N_LANES(4), .WIDTH(8)) if_b ();
    lane_if #(.N_LANES(1), .WIDTH(4)) if_c ();
    lane_if #(.N_LANES(4), .WIDTH(4)) if_d ();

    lane_sweep #(.N_LANES(8), .WIDTH(1)) u_a (
        .i_clk(clk), .i_arst_n(rst_n), .p(if_a.drv), .i_start(a_start), .i_mode(a_mode),
        .i_value(a_value), .i_abort(a_abort), .o_busy(a_busy), .o_done(a_done));
    lane_sweep #(.N_LANES(4), .WIDTH(8)) u_b (
        .i_clk(clk), .i_arst_n(rst_n), .p(if_b.drv), .i_start(b_start), .i_mode(b_mode),
        .i_value(b_value), .i_abort(b_abort), .o_busy(b_busy), .o_done(b_done));
    lane_sweep #(.N_LANES(1), .WIDTH(4)) u_c (
        .i_clk(clk), .i_arst_n(rst_n), .p(if_c.drv), .i_start(c_start), .i_mode(c_mode),
        .i_value(c_value), .i_abort(c_abort), .o_busy(c_busy), .o_done(c_done));
    lane_sweep #(.N_LANES(4), .WIDTH(4)) u_d (
        .i_clk(clk), .i_arst_n(rst_n), .p(if_d.drv), .i_start(d_start), .i_mode(d_mode),
        .i_value(d_value), .i_abort(d_abort), .o_busy(d_busy), .o_done(d_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int k = 0; k < 8; k++) begin
            nvec++;
            if (if_a.lanes[k] !== 1'b0) begin
                nerr++; $display("FAIL reset_a_lane%0d: got %h expected 0", k, if_a.lanes[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (if_b.lanes[k] !== 8'h00 || if_d.lanes[k] !== 4'h0) begin
                nerr++; $display("FAIL reset_bd_lane%0d: got %h/%h expected 0", k, if_b.lanes[k], if_d.lanes[k]);
            end
        end
        nvec++;
        if (if_c.lanes[0] !== 4'h0) begin
            nerr++; $display("FAIL reset_c_lane0: got %h expected 0", if_c.lanes[0]);
        end
        nvec++;
        if ({a_busy, a_done, b_busy, b_done, c_busy, c_done, d_busy, d_done} !== 8'h00) begin
            nerr++; $display("FAIL reset_flags: got %b expected 00000000",
                             {a_busy, a_done, b_busy, b_done, c_busy, c_done, d_busy, d_done});
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_broadcast();
        a_start = 1'b1; a_mode = 1'b0; a_value = 1'b1;
        tick();
        a_start = 1'b0; a_value = 1'b0;
        for (int k = 0; k < 8; k++) begin
            nvec++;
            if (if_a.lanes[k] !== 1'b1) begin
                nerr++; $display("FAIL bcast_lane%0d: got %h expected 1", k, if_a.lanes[k]);
            end
        end
        nvec++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            nerr++; $display("FAIL bcast_flags: got done=%b busy=%b expected done=1 busy=0", a_done, a_busy);
        end
        tick();
        nvec++;
        if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            nerr++; $display("FAIL bcast_after: got done=%b busy=%b expected done=0 busy=0", a_done, a_busy);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_l [4];
        logic       exp_busy, exp_done;
        b_start = 1'b1; b_mode = 1'b0; b_value = 8'h3C;
        tick();
        b_start = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) exp_l[k] = 8'h3C;
        b_start = 1'b1; b_mode = 1'b1; b_value = 8'hA5;
        for (int j = 0; j < 4; j++) begin
            tick();
            b_start = 1'b0; b_value = 8'h00;
            exp_l[j] = 8'hA5;
            exp_busy = (j < 3);
            exp_done = (j == 3);
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if (if_b.lanes[k] !== exp_l[k]) begin
                    nerr++; $display("FAIL sweep_e%0d_lane%0d: got %h expected %h", j, k, if_b.lanes[k], exp_l[k]);
                end
            end
            nvec++;
            if (b_busy !== exp_busy || b_done !== exp_done) begin
                nerr++; $display("FAIL sweep_e%0d_flags: got busy=%b done=%b expected busy=%b done=%b",
                                 j, b_busy, b_done, exp_busy, exp_done);
            end
        end
        tick();
        nvec++;
        if (b_busy !== 1'b0 || b_done !== 1'b0) begin
            nerr++; $display("FAIL sweep_after: got busy=%b done=%b expected 0 0", b_busy, b_done);
        end
    endtask

    task automatic test_abort();
        logic [7:0] exp_l [4];
        b_start = 1'b1; b_mode = 1'b0; b_value = 8'h11;
        tick();
        b_start = 1'b1; b_mode = 1'b1; b_value = 8'hA5;
        tick();
        b_start = 1'b0;
        tick();
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        exp_l[0] = 8'hA5; exp_l[1] = 8'hA5; exp_l[2] = 8'h11; exp_l[3] = 8'h11;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if (if_b.lanes[k] !== exp_l[k]) begin
                    nerr++; $display("FAIL abort_r%0d_lane%0d: got %h expected %h", r, k, if_b.lanes[k], exp_l[k]);
                end
            end
            nvec++;
            if (b_busy !== 1'b0 || b_done !== 1'b0) begin
                nerr++; $display("FAIL abort_r%0d_flags: got busy=%b done=%b expected 0 0", r, b_busy, b_done);
            end
            tick();
        end
    endtask

    task automatic test_idle_abort();
        b_start = 1'b1; b_mode = 1'b0; b_value = 8'h77; b_abort = 1'b1;
        tick();
        b_start = 1'b0; b_abort = 1'b0;
        nvec++;
        if (if_b.lanes[0] !== 8'hA5 || if_b.lanes[3] !== 8'h11) begin
            nerr++; $display("FAIL idle_abort_lanes: got %h %h expected a5 11", if_b.lanes[0], if_b.lanes[3]);
        end
        nvec++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            nerr++; $display("FAIL idle_abort_flags: got done=%b busy=%b expected 0 0", b_done, b_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_l [4];
        logic       exp_done;
        exp_l[0] = 8'h22; exp_l[1] = 8'hA5; exp_l[2] = 8'h11; exp_l[3] = 8'h11;
        b_start = 1'b1; b_mode = 1'b1; b_value = 8'h22;
        tick();
        b_mode = 1'b0; b_value = 8'h99;
        for (int j = 1; j < 4; j++) begin
            tick();
            exp_l[j] = 8'h22;
            exp_done = (j == 3);
            for (int k = 0; k < 4; k++) begin
                nvec++;
                if (if_b.lanes[k] !== exp_l[k]) begin
                    nerr++; $display("FAIL held_start_e%0d_lane%0d: got %h expected %h", j, k, if_b.lanes[k], exp_l[k]);
                end
            end
            nvec++;
            if (b_done !== exp_done) begin
                nerr++; $display("FAIL held_start_e%0d_done: got %b expected %b", j, b_done, exp_done);
            end
        end
        b_start = 1'b0;
        tick();
        nvec++;
        if (if_b.lanes[1] !== 8'h22 || b_busy !== 1'b0 || b_done !== 1'b0) begin
            nerr++; $display("FAIL held_start_after: got lane1=%h busy=%b done=%b expected 22 0 0",
                             if_b.lanes[1], b_busy, b_done);
        end
    endtask

    task automatic test_single_lane();
        c_start = 1'b1; c_mode = 1'b1; c_value = 4'h9;
        tick();
        c_start = 1'b0; c_value = 4'h0;
        nvec++;
        if (if_c.lanes[0] !== 4'h9 || c_done !== 1'b1 || c_busy !== 1'b0) begin
            nerr++; $display("FAIL n1_sweep: got lane=%h done=%b busy=%b expected 9 1 0",
                             if_c.lanes[0], c_done, c_busy);
        end
        tick();
        nvec++;
        if (if_c.lanes[0] !== 4'h9 || c_done !== 1'b0 || c_busy !== 1'b0) begin
            nerr++; $display("FAIL n1_after: got lane=%h done=%b busy=%b expected 9 0 0",
                             if_c.lanes[0], c_done, c_busy);
        end
        c_start = 1'b1; c_mode = 1'b0; c_value = 4'h6;
        tick();
        c_start = 1'b0;
        nvec++;
        if (if_c.lanes[0] !== 4'h6 || c_done !== 1'b1) begin
            nerr++; $display("FAIL n1_bcast: got lane=%h done=%b expected 6 1", if_c.lanes[0], c_done);
        end
    endtask

    task automatic test_incr();
        logic [3:0] exp_l [4];
`ifdef LANE_SWEEP_INCR_EN
        exp_l[0] = 4'hE; exp_l[1] = 4'hF; exp_l[2] = 4'h0; exp_l[3] = 4'h1;
`else
        exp_l[0] = 4'hE; exp_l[1] = 4'hE; exp_l[2] = 4'hE; exp_l[3] = 4'hE;
`endif
        d_start = 1'b1; d_mode = 1'b1; d_value = 4'hE;
        for (int j = 0; j < 4; j++) begin
            tick();
            d_start = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (if_d.lanes[k] !== exp_l[k]) begin
                nerr++; $display("FAIL incr_lane%0d: got %h expected %h", k, if_d.lanes[k], exp_l[k]);
            end
        end
        nvec++;
        if (d_done !== 1'b1) begin
            nerr++; $display("FAIL incr_done: got %b expected 1", d_done);
        end
        d_start = 1'b1; d_mode = 1'b0; d_value = 4'h5;
        tick();
        d_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (if_d.lanes[k] !== 4'h5) begin
                nerr++; $display("FAIL incr_bcast_lane%0d: got %h expected 5", k, if_d.lanes[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        b_start = 1'b1; b_mode = 1'b1; b_value = 8'h44;
        tick();
        b_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (if_b.lanes[k] !== 8'h00) begin
                nerr++; $display("FAIL rst_mid_lane%0d: got %h expected 00", k, if_b.lanes[k]);
            end
        end
        nvec++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || if_a.lanes[0] !== 1'b0) begin
            nerr++; $display("FAIL rst_mid_flags: got busy=%b done=%b a0=%b expected 0 0 0",
                             b_busy, b_done, if_a.lanes[0]);
        end
        tick();
        rst_n = 1'b1;
        tick();
        b_start = 1'b1; b_mode = 1'b0; b_value = 8'h03;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nvec++;
            if (if_b.lanes[k] !== 8'h03) begin
                nerr++; $display("FAIL rst_bcast_lane%0d: got %h expected 03", k, if_b.lanes[k]);
            end
        end
        nvec++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
            nerr++; $display("FAIL rst_bcast_flags: got done=%b busy=%b expected 1 0", b_done, b_busy);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        a_start = 1'b0; a_mode = 1'b0; a_abort = 1'b0; a_value = '0;
        b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0; b_value = '0;
        c_start = 1'b0; c_mode = 1'b0; c_abort = 1'b0; c_value = '0;
        d_start = 1'b0; d_mode = 1'b0; d_abort = 1'b0; d_value = '0;
        test_reset();
        test_broadcast();
        test_sweep();
        test_abort();
        test_idle_abort();
        test_back_to_back();
        test_single_lane();
        test_incr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
